// File: rtl/hazard_pkg.sv
// Shared types for the hazard tracker: the per-stage destination-register
// slot, the empty (bubble) slot value and the "live write" test.
package hazard_pkg;

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic       valid;
      logic [4:0] Rd;
      logic       RegWrite;
      logic       MemRead;
      logic       setFlags;
   } stage_slot_t;

   localparam stage_slot_t BUBBLE_SLOT = '{
      valid:    1'b0,
      Rd:       XZR,
      RegWrite: 1'b0,
      MemRead:  1'b0,
      setFlags: 1'b0
   };

   // A slot is live for register r when it will really write r; XZR never counts.
   function automatic logic slotLive(input stage_slot_t slot, input logic [4:0] r);
      return slot.valid & slot.RegWrite & (slot.Rd == r) & (r != XZR);
   endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One pipeline-stage slot register. Holds the destination-register state of
// the instruction in its stage, or a bubble after reset or on request.
module hazard_slot_reg
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        bubbleIn,
   input  stage_slot_t slotIn,
   output stage_slot_t slotOut
);

   // Capture the upstream slot each cycle, substituting a bubble when asked.
   always_ff @(posedge clk) begin
      if (reset) begin
         slotOut <= BUBBLE_SLOT;
      end else if (bubbleIn) begin
         slotOut <= BUBBLE_SLOT;
      end else begin
         slotOut <= slotIn;
      end
   end

endmodule

// File: rtl/hazard_tracker.sv
// Producer side of the operand-forwarding interface. Tracks the EX and MEM
// destination registers, raises stalls for load-use and CBZ operand hazards
// that forwarding cannot cover, flushes IF/ID on taken branches and counts
// both events with saturating counters.
module hazard_tracker
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_Rd,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             id_setFlags,
   input  logic [4:0]       id_Rn,
   input  logic [4:0]       id_Rm,
   input  logic             id_usesRn,
   input  logic             id_usesRm,
   input  logic             id_isCbz,
   input  logic             br_taken,
   output logic [4:0]       AwEx,
   output logic [4:0]       AwMem,
   output logic             RegWriteEX,
   output logic             RegWriteMEM,
   output logic             flagSignalEX,
   output logic             stall,
   output logic             flush_ifid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   stage_slot_t idSlot;
   stage_slot_t exSlot;
   stage_slot_t memSlot;
   logic        exBubble;
   logic        loadUseHazard;
   logic        cbzHazard;
   logic        unusedMemFlags;

   assign idSlot = '{
      valid:    1'b1,
      Rd:       id_Rd,
      RegWrite: id_RegWrite,
      MemRead:  id_MemRead,
      setFlags: id_setFlags
   };

   // A stalled or empty ID stage sends a bubble into EX.
   assign exBubble = stall | ~id_valid;

   hazard_slot_reg exReg (
      .clk      (clk),
      .reset    (reset),
      .bubbleIn (exBubble),
      .slotIn   (idSlot),
      .slotOut  (exSlot)
   );

   hazard_slot_reg memReg (
      .clk      (clk),
      .reset    (reset),
      .bubbleIn (1'b0),
      .slotIn   (exSlot),
      .slotOut  (memSlot)
   );

   assign AwEx         = exSlot.Rd;
   assign AwMem        = memSlot.Rd;
   assign RegWriteEX   = exSlot.valid & exSlot.RegWrite;
   assign RegWriteMEM  = memSlot.valid & memSlot.RegWrite;
   assign flagSignalEX = exSlot.valid & exSlot.setFlags;

   // The MEM flag bit travels with the slot but nothing downstream reads it.
   assign unusedMemFlags = memSlot.setFlags;

   // A load in EX cannot forward yet to an ALU operand being read in ID.
   assign loadUseHazard = slotLive(exSlot, exSlot.Rd) & exSlot.MemRead &
                          ((id_usesRn & (id_Rn == exSlot.Rd)) |
                           (id_usesRm & (id_Rm == exSlot.Rd)));

   // CBZ compares in ID, so any EX producer or a MEM load of Rt must wait.
   assign cbzHazard = id_isCbz &
                      (slotLive(exSlot, id_Rm) |
                       (slotLive(memSlot, id_Rm) & memSlot.MemRead));

   assign stall      = id_valid & (loadUseHazard | cbzHazard);
   assign flush_ifid = br_taken & ~stall;

   // Saturating count of stall cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   // Saturating count of flush cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt <= '0;
      end else if (flush_ifid && (flush_cnt != CNT_MAX)) begin
         flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule
